mc_datapath_regs: RTL and testbench
===================================

# mc_datapath_regs

Architectural state-register and steering block of the multicycle CPU, sitting directly downstream of the FSM control circuit. It owns PC, IR, MDR, A, B and ALUOut, and applies the controller's per-state enables and mux selects to them. It produces the memory address, ALU operands, register-file write address and data, and the opcode/funct fields fed back to the controller and ALU control.

## Interface
Parameters:
- DATA_W, 32, datapath width; fixed at 32 for instruction-field decode
- RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
- clk  in  1  system clock; all state updates on posedge
- reset  in  1  asynchronous, active-low reset
- PCWrite, PCwriteCond, IorD, IRWrite, memToReg, RegDest, ALUsrcA  in  1 each  controller outputs
- PCSource, ALUsrcB  in  2 each  controller mux selects
- mem_rdata  in  32  memory read data
- rf_rdata1, rf_rdata2  in  32  register-file read ports (rs, rt)
- alu_result  in  32  combinational ALU output
- alu_zero  in  1  ALU zero flag
- pc  out  32  program counter register
- ir  out  32  instruction register
- opcode  out  6  ir[31:26], to controller instr
- funct  out  6  ir[5:0], to ALU control
- rs_addr, rt_addr  out  5 each  ir[25:21], ir[20:16]
- mem_addr  out  32  IorD ? alu_out : pc
- mem_wdata  out  32  B register
- alu_a  out  32  ALUsrcA ? A : pc
- alu_b  out  32  per ALUsrcB: 00 B, 01 32'd4, 10 sext(ir[15:0]), 11 sext(ir[15:0])<<2
- rf_waddr  out  5  RegDest ? ir[15:11] : ir[20:16]
- rf_wdata  out  32  memToReg ? mdr : alu_out
- alu_out  out  32  ALUOut register
- instr_count  out  32  count of IRWrite cycles

## Operation
- Reset (reset low, asynchronous): pc=RESET_PC; ir, mdr, A, B, alu_out and instr_count = 0. All combinational outputs follow from these values.
- PC update: pc_we = PCWrite | (PCwriteCond & alu_zero). When pc_we is high, pc takes next_pc:
  - PCSource 00: alu_result
  - PCSource 01: alu_out
  - PCSource 10: jump target (see Configuration)
  - PCSource 11: reserved; pc holds even when pc_we is high
- Both PCWrite and PCwriteCond high: write occurs regardless of alu_zero.
- IR loads mem_rdata only when IRWrite=1. instr_count increments on the same edge and wraps from 32'hFFFF_FFFF to 0.
- MDR, A (rf_rdata1), B (rf_rdata2) and alu_out (alu_result) load unconditionally every cycle.
- Arithmetic: pc+4 is computed by the external ALU. Wrap at 2^32 is natural with no flag. Sign extension replicates ir[15].
- Simultaneous IRWrite and pc_we: both registers update on the same edge from pre-edge values, so IR gets mem_rdata addressed by the old pc.
- Reset asserted mid-instruction: all state clears immediately. The first posedge after deassertion behaves as a normal cycle using reset values.

## Timing
- The controller drives outputs on negedge clk, so controls are stable for half a cycle before the posedge that samples them.
- Register latency: 1 cycle from control/data valid to register output.
- mem_addr, alu_a, alu_b, rf_waddr and rf_wdata are purely combinational from registers and controls, with 0-cycle latency.
- No handshake: memory is assumed single-cycle. mem_rdata must be valid before the posedge in the cycle IorD/IRWrite select it.

## Configuration
- JUMP_EN defined: PCSource 10 selects {pc[31:28], ir[25:0], 2'b00}.
- JUMP_EN undefined: PCSource 10 is treated as reserved and pc holds. The jump-target logic is not synthesised.

## Structure
- Package mc_pkg holds:
  - PCSource encodings PCSRC_ALU/PCSRC_ALUOUT/PCSRC_JUMP/PCSRC_RSVD
  - ALUsrcB encodings SRCB_B/SRCB_FOUR/SRCB_IMM/SRCB_IMM_SH2
  - IR field bit-position constants
- Sub-module mc_en_reg: a DATA_W-wide enable register with async active-low reset and a reset-value parameter. It is instantiated for pc, ir, mdr, A, B and alu_out.

## Test plan
- Reset low mid-run with pc=32'h40: pc returns to RESET_PC and ir=0 immediately, without waiting for a clock edge.
- Fetch: mem_rdata=32'h2002_0005, IRWrite=1, PCWrite=1, PCSource=00, alu_result=32'h4. Next edge: ir=32'h2002_0005, pc=4, opcode=6'b001000, instr_count=1.
- Branch:
  - PCwriteCond=1, alu_zero=0, alu_out=32'h100, PCSource=01 gives pc unchanged.
  - Same with alu_zero=1 gives pc=32'h100.
- Jump: ir=32'h0800_0010, pc=32'h4000_0008, PCWrite=1, PCSource=10.
  - With JUMP_EN: pc=32'h4000_0040.
  - Without JUMP_EN: pc unchanged.
- Operand muxes with ir[15:0]=16'hFFFC:
  - ALUsrcB=10 gives alu_b=32'hFFFF_FFFC.
  - ALUsrcB=11 gives alu_b=32'hFFFF_FFF0.
  - ALUsrcB=01 gives alu_b=4.
  - IorD=1 gives mem_addr=alu_out.
- Writeback: memToReg=1, RegDest=0 gives rf_wdata=mdr and rf_waddr=ir[20:16]. PCSource=11 with PCWrite=1 leaves pc held.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared encodings and instruction-field positions for the multicycle datapath.
package mc_pkg;

    typedef enum logic [1:0] {
        PCSRC_ALU    = 2'b00,
        PCSRC_ALUOUT = 2'b01,
        PCSRC_JUMP   = 2'b10,
        PCSRC_RSVD   = 2'b11
    } pc_src_e;

    typedef enum logic [1:0] {
        SRCB_B       = 2'b00,
        SRCB_FOUR    = 2'b01,
        SRCB_IMM     = 2'b10,
        SRCB_IMM_SH2 = 2'b11
    } srcb_e;

    localparam int IR_OP_HI  = 31;
    localparam int IR_OP_LO  = 26;
    localparam int IR_RS_HI  = 25;
    localparam int IR_RS_LO  = 21;
    localparam int IR_RT_HI  = 20;
    localparam int IR_RT_LO  = 16;
    localparam int IR_RD_HI  = 15;
    localparam int IR_RD_LO  = 11;
    localparam int IR_IMM_HI = 15;
    localparam int IR_IMM_LO = 0;
    localparam int IR_FN_HI  = 5;
    localparam int IR_FN_LO  = 0;

    function automatic logic [31:0] sext16(input logic [15:0] imm);
        return {{16{imm[15]}}, imm};
    endfunction

endpackage

// File: rtl/mc_en_reg.sv
// Enable register with asynchronous active-low reset to a parameterised value.
module mc_en_reg #(
    parameter int           W         = 32,
    parameter logic [W-1:0] RESET_VAL = '0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            q <= RESET_VAL;
        else if (en)
            q <= d;
    end

endmodule

// File: rtl/mc_datapath_regs.sv
// Multicycle CPU state registers (PC, IR, MDR, A, B, ALUOut) and operand/writeback steering.
// Optional macro JUMP_EN enables the PCSource=10 jump target; otherwise that encoding holds pc.
module mc_datapath_regs #(
    parameter int          DATA_W   = 32,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              PCWrite,
    input  logic              PCwriteCond,
    input  logic              IorD,
    input  logic              IRWrite,
    input  logic              memToReg,
    input  logic              RegDest,
    input  logic              ALUsrcA,
    input  logic [1:0]        PCSource,
    input  logic [1:0]        ALUsrcB,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic [DATA_W-1:0] rf_rdata1,
    input  logic [DATA_W-1:0] rf_rdata2,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_zero,
    output logic [DATA_W-1:0] pc,
    output logic [DATA_W-1:0] ir,
    output logic [5:0]        opcode,
    output logic [5:0]        funct,
    output logic [4:0]        rs_addr,
    output logic [4:0]        rt_addr,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] alu_a,
    output logic [DATA_W-1:0] alu_b,
    output logic [4:0]        rf_waddr,
    output logic [DATA_W-1:0] rf_wdata,
    output logic [DATA_W-1:0] alu_out,
    output logic [DATA_W-1:0] instr_count
);
    import mc_pkg::*;

    logic [DATA_W-1:0] mdr, a_q, b_q;
    logic [DATA_W-1:0] next_pc, imm_ext;
    logic              pc_src_ok, pc_we;

    // No handshake: controls arrive on negedge and everything is sampled on the next posedge.
    always_comb begin
        next_pc   = alu_result;
        pc_src_ok = 1'b1;
        case (pc_src_e'(PCSource))
            PCSRC_ALU:    next_pc = alu_result;
            PCSRC_ALUOUT: next_pc = alu_out;
`ifdef JUMP_EN
            PCSRC_JUMP:   next_pc = {pc[31:28], ir[IR_RS_HI:IR_IMM_LO], 2'b00};
`endif
            default:      pc_src_ok = 1'b0;
        endcase
    end

    // Reserved (and, without JUMP_EN, jump) encodings suppress the write entirely.
    assign pc_we = (PCWrite | (PCwriteCond & alu_zero)) & pc_src_ok;

    mc_en_reg #(.W(DATA_W), .RESET_VAL(RESET_PC)) u_pc (
        .clk(clk), .reset(reset), .en(pc_we), .d(next_pc), .q(pc));
    mc_en_reg #(.W(DATA_W), .RESET_VAL('0)) u_ir (
        .clk(clk), .reset(reset), .en(IRWrite), .d(mem_rdata), .q(ir));
    mc_en_reg #(.W(DATA_W), .RESET_VAL('0)) u_mdr (
        .clk(clk), .reset(reset), .en(1'b1), .d(mem_rdata), .q(mdr));
    mc_en_reg #(.W(DATA_W), .RESET_VAL('0)) u_a (
        .clk(clk), .reset(reset), .en(1'b1), .d(rf_rdata1), .q(a_q));
    mc_en_reg #(.W(DATA_W), .RESET_VAL('0)) u_b (
        .clk(clk), .reset(reset), .en(1'b1), .d(rf_rdata2), .q(b_q));
    mc_en_reg #(.W(DATA_W), .RESET_VAL('0)) u_alu_out (
        .clk(clk), .reset(reset), .en(1'b1), .d(alu_result), .q(alu_out));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            instr_count <= '0;
        else if (IRWrite)
            instr_count <= instr_count + 32'd1;
    end

    assign opcode    = ir[IR_OP_HI:IR_OP_LO];
    assign funct     = ir[IR_FN_HI:IR_FN_LO];
    assign rs_addr   = ir[IR_RS_HI:IR_RS_LO];
    assign rt_addr   = ir[IR_RT_HI:IR_RT_LO];
    assign imm_ext   = sext16(ir[IR_IMM_HI:IR_IMM_LO]);

    assign mem_addr  = IorD ? alu_out : pc;
    assign mem_wdata = b_q;
    assign alu_a     = ALUsrcA ? a_q : pc;
    assign rf_waddr  = RegDest ? ir[IR_RD_HI:IR_RD_LO] : ir[IR_RT_HI:IR_RT_LO];
    assign rf_wdata  = memToReg ? mdr : alu_out;

    always_comb begin
        alu_b = b_q;
        case (srcb_e'(ALUsrcB))
            SRCB_B:       alu_b = b_q;
            SRCB_FOUR:    alu_b = 32'd4;
            SRCB_IMM:     alu_b = imm_ext;
            SRCB_IMM_SH2: alu_b = {imm_ext[29:0], 2'b00};
            default:      alu_b = b_q;
        endcase
    end

endmodule

// File: tb/tb_mc_datapath_regs.sv
// Directed bench for mc_datapath_regs: reset, fetch/branch/jump vectors, operand muxes, async reset.
module tb_mc_datapath_regs;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef JUMP_EN
    localparam logic [31:0] JMP_PC = 32'h4000_0040;
`else
    localparam logic [31:0] JMP_PC = 32'h4000_0008;
`endif

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        PCWrite = 1'b0, PCwriteCond = 1'b0, IorD = 1'b0, IRWrite = 1'b0;
    logic        memToReg = 1'b0, RegDest = 1'b0, ALUsrcA = 1'b0, alu_zero = 1'b0;
    logic [1:0]  PCSource = 2'b00, ALUsrcB = 2'b00;
    logic [31:0] mem_rdata = '0, rf_rdata1 = '0, rf_rdata2 = '0, alu_result = '0;
    logic [31:0] pc, ir, mem_addr, mem_wdata, alu_a, alu_b, rf_wdata, alu_out, instr_count;
    logic [5:0]  opcode, funct;
    logic [4:0]  rs_addr, rt_addr, rf_waddr;

    mc_datapath_regs #(.DATA_W(32), .RESET_PC(RESET_PC)) dut (
        .clk(clk), .reset(reset),
        .PCWrite(PCWrite), .PCwriteCond(PCwriteCond), .IorD(IorD), .IRWrite(IRWrite),
        .memToReg(memToReg), .RegDest(RegDest), .ALUsrcA(ALUsrcA),
        .PCSource(PCSource), .ALUsrcB(ALUsrcB),
        .mem_rdata(mem_rdata), .rf_rdata1(rf_rdata1), .rf_rdata2(rf_rdata2),
        .alu_result(alu_result), .alu_zero(alu_zero),
        .pc(pc), .ir(ir), .opcode(opcode), .funct(funct),
        .rs_addr(rs_addr), .rt_addr(rt_addr),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .alu_a(alu_a), .alu_b(alu_b),
        .rf_waddr(rf_waddr), .rf_wdata(rf_wdata), .alu_out(alu_out),
        .instr_count(instr_count)
    );

    // clock / reset
    always #5 clk = ~clk;

    typedef struct {
        logic        pcw, pcc, iord, irw, m2r, rdst, srca;
        logic [1:0]  psrc, srcb;
        logic        zero;
        logic [31:0] mrd, rf1, rf2, alu_res;
        logic [31:0] e_pc, e_ir, e_cnt, e_alu_a, e_alu_b, e_maddr;
        logic [4:0]  e_waddr;
        logic [31:0] e_wdata;
    } vec_t;

    vec_t        vecs[10];
    logic [31:0] exp_q[$];
    int          n_total = 0;
    int          n_pass  = 0;

    // scoreboard: pop next expectation and compare
    task automatic chk(input string nm, input logic [31:0] act);
        logic [31:0] e;
        n_total++;
        if (exp_q.size() == 0) begin
            $display("FAIL %s: no expected value queued, got %h", nm, act);
            return;
        end
        e = exp_q.pop_front();
        if (act === e)
            n_pass++;
        else
            $display("FAIL %s: got %h expected %h", nm, act, e);
    endtask

    task automatic expect_chk(input string nm, input logic [31:0] act, input logic [31:0] e);
        exp_q.push_back(e);
        chk(nm, act);
    endtask

    // driver
    task automatic drive(input vec_t v);
        PCWrite = v.pcw; PCwriteCond = v.pcc; IorD = v.iord; IRWrite = v.irw;
        memToReg = v.m2r; RegDest = v.rdst; ALUsrcA = v.srca;
        PCSource = v.psrc; ALUsrcB = v.srcb; alu_zero = v.zero;
        mem_rdata = v.mrd; rf_rdata1 = v.rf1; rf_rdata2 = v.rf2; alu_result = v.alu_res;
    endtask

    task automatic idle_ctrl();
        PCWrite = 0; PCwriteCond = 0; IorD = 0; IRWrite = 0;
        memToReg = 0; RegDest = 0; ALUsrcA = 0; PCSource = 2'b00; ALUsrcB = 2'b00; alu_zero = 0;
    endtask

    initial begin
        // pcw pcc iord irw m2r rdst srca psrc srcb zero | mrd rf1 rf2 alu_res | pc ir cnt alu_a alu_b maddr waddr wdata
        vecs[0] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b0,1'b0,2'b00,2'b01,1'b0,
                    32'h2002_0005,32'h11,32'h22,32'h4,
                    32'h4,32'h2002_0005,32'd1,32'h4,32'h4,32'h4,5'd2,32'h4};
        vecs[1] = '{1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,2'b11,1'b0,
                    32'h0,32'h33,32'h44,32'h100,
                    32'h4,32'h2002_0005,32'd1,32'h4,32'h14,32'h4,5'd2,32'h100};
        vecs[2] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,2'b00,1'b0,
                    32'h0,32'h33,32'h44,32'h100,
                    32'h4,32'h2002_0005,32'd1,32'h33,32'h44,32'h4,5'd2,32'h100};
        vecs[3] = '{1'b0,1'b1,1'b0,1'b0,1'b0,1'b0,1'b1,2'b01,2'b00,1'b1,
                    32'h0,32'h33,32'h44,32'h100,
                    32'h100,32'h2002_0005,32'd1,32'h33,32'h44,32'h100,5'd2,32'h100};
        vecs[4] = '{1'b1,1'b1,1'b1,1'b0,1'b0,1'b0,1'b0,2'b00,2'b10,1'b0,
                    32'h0,32'h33,32'h44,32'h200,
                    32'h200,32'h2002_0005,32'd1,32'h200,32'h5,32'h200,5'd2,32'h200};
        vecs[5] = '{1'b1,1'b0,1'b0,1'b1,1'b1,1'b0,1'b1,2'b00,2'b10,1'b0,
                    32'h8C43_FFFC,32'h1000,32'h55,32'h204,
                    32'h204,32'h8C43_FFFC,32'd2,32'h1000,32'hFFFF_FFFC,32'h204,5'd3,32'h8C43_FFFC};
        vecs[6] = '{1'b0,1'b0,1'b1,1'b0,1'b1,1'b1,1'b0,2'b00,2'b11,1'b0,
                    32'hCAFE_F00D,32'h1000,32'h55,32'h1234,
                    32'h204,32'h8C43_FFFC,32'd2,32'h204,32'hFFFF_FFF0,32'h1234,5'd31,32'hCAFE_F00D};
        vecs[7] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,2'b11,2'b01,1'b0,
                    32'h0,32'h1000,32'h55,32'h999,
                    32'h204,32'h8C43_FFFC,32'd2,32'h1000,32'h4,32'h999,5'd3,32'h999};
        vecs[8] = '{1'b1,1'b0,1'b0,1'b1,1'b0,1'b1,1'b0,2'b00,2'b10,1'b0,
                    32'h0800_0010,32'h1000,32'h55,32'h4000_0008,
                    32'h4000_0008,32'h0800_0010,32'd3,32'h4000_0008,32'h10,32'h4000_0008,5'd0,32'h4000_0008};
        vecs[9] = '{1'b1,1'b0,1'b1,1'b0,1'b0,1'b0,1'b1,2'b10,2'b01,1'b0,
                    32'h0,32'h1000,32'h55,32'h77,
                    JMP_PC,32'h0800_0010,32'd3,32'h1000,32'h4,32'h77,5'd0,32'h77};

        // reset state, held across a couple of edges
        #1 reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        expect_chk("rst_pc", pc, RESET_PC);
        expect_chk("rst_ir", ir, 32'h0);
        expect_chk("rst_cnt", instr_count, 32'h0);
        expect_chk("rst_alu_out", alu_out, 32'h0);
        expect_chk("rst_mem_wdata", mem_wdata, 32'h0);
        expect_chk("rst_mem_addr", mem_addr, RESET_PC);
        @(negedge clk);
        reset = 1'b1;

        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk);
            #1;
            expect_chk($sformatf("v%0d_pc", i), pc, vecs[i].e_pc);
            expect_chk($sformatf("v%0d_ir", i), ir, vecs[i].e_ir);
            expect_chk($sformatf("v%0d_cnt", i), instr_count, vecs[i].e_cnt);
            expect_chk($sformatf("v%0d_alu_a", i), alu_a, vecs[i].e_alu_a);
            expect_chk($sformatf("v%0d_alu_b", i), alu_b, vecs[i].e_alu_b);
            expect_chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_maddr);
            expect_chk($sformatf("v%0d_rf_waddr", i), {27'd0, rf_waddr}, {27'd0, vecs[i].e_waddr});
            expect_chk($sformatf("v%0d_rf_wdata", i), rf_wdata, vecs[i].e_wdata);
            expect_chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].rf2);
            if (i == 0) begin
                expect_chk("fetch_opcode", {26'd0, opcode}, 32'h08);
                expect_chk("fetch_funct", {26'd0, funct}, 32'h05);
                expect_chk("fetch_rs", {27'd0, rs_addr}, 32'd0);
                expect_chk("fetch_rt", {27'd0, rt_addr}, 32'd2);
            end
        end

        // asynchronous reset mid-run with pc = 0x40
        @(negedge clk);
        idle_ctrl();
        PCWrite = 1'b1; alu_result = 32'h40; mem_rdata = 32'h0;
        @(posedge clk);
        #1;
        expect_chk("pre_rst_pc", pc, 32'h40);
        #2 reset = 1'b0;
        #1;
        expect_chk("async_rst_pc", pc, RESET_PC);
        expect_chk("async_rst_ir", ir, 32'h0);
        expect_chk("async_rst_cnt", instr_count, 32'h0);
        expect_chk("async_rst_alu_out", alu_out, 32'h0);

        // first edge after release is an ordinary fetch from reset values
        @(negedge clk);
        reset = 1'b1;
        IRWrite = 1'b1; PCWrite = 1'b1; PCSource = 2'b00;
        mem_rdata = 32'h2002_0005; alu_result = 32'h4;
        @(posedge clk);
        #1;
        expect_chk("post_rst_pc", pc, 32'h4);
        expect_chk("post_rst_ir", ir, 32'h2002_0005);
        expect_chk("post_rst_cnt", instr_count, 32'd1);
        @(negedge clk);
        idle_ctrl();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
